fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction-fetch stage directly downstream of the program-counter register.
//  Takes the current pc, issues word reads to instruction memory over a req/gnt/rvalid bus,
//  and buffers up to DEPTH {pc, instruction} pairs in issue order.
//  Hands pairs to decode with a valid/ready handshake.
//  Drives pc_advance so the PC register loads newPC only when the current pc has been issued.
//  flush (branch/jump redirect) empties the queue and squashes in-flight responses.
// PARAMETERS
//  DEPTH   4   queue entries = max issued-but-undelivered fetches; power of two, >= 2
//  AW      32  address / pc width
//  DW      32  instruction width
// PORTS
//  clk          in   1    clock, rising edge
//  rst          in   1    asynchronous reset, active high
//  pc           in   AW   current pc from PC register
//  pc_advance   out  1    1 = pc accepted this cycle; upstream loads newPC at this edge
//  flush        in   1    discard all queued and in-flight fetches
//  imem_req     out  1    fetch request
//  imem_addr    out  AW   fetch address = {pc[AW-1:2], 2'b00}
//  imem_gnt     in   1    request accepted this cycle
//  imem_rvalid  in   1    read data valid; one per grant, in order, >= 1 cycle after gnt
//  imem_rdata   in   DW   instruction word
//  inst_valid   out  1    head entry holds returned data
//  inst_ready   in   1    decode accepts head
//  inst         out  DW   head instruction
//  inst_pc      out  AW   pc of head instruction
// BEHAVIOUR
//  Reset (async, rst=1): head/tail/fill ptrs=0, used=0, discard=0, all slot-filled bits=0.
//   Outputs: imem_req=0, pc_advance=0, inst_valid=0, inst=0, inst_pc=0.
//  Slots: circular buffer of DEPTH entries {pc, data, filled}.
//   used = number of allocated slots, width log2(DEPTH)+1.
//  Issue: imem_req = (used < DEPTH) & ~flush, from registered state only (no same-cycle dequeue bypass).
//   pc_advance = imem_req & imem_gnt.
//   On pc_advance: slot[tail].pc<=pc, filled<=0, tail++ (wraps modulo DEPTH).
//  Fill: on imem_rvalid with discard==0: slot[fill].data<=imem_rdata, filled<=1, fill++.
//   On imem_rvalid with discard>0: data dropped, discard--.
//  Deliver: inst_valid = slot[head].filled & (used>0); inst/inst_pc = slot[head], combinational from regs.
//   On inst_valid & inst_ready: filled<=0, head++.
//   Latency: rvalid at edge N -> inst_valid high after edge N (1 cycle).
//  used update: +1 on pc_advance, -1 on dequeue; both together -> unchanged.
//  Flush (sampled at edge): head=tail=fill=0, used=0, all filled=0.
//   discard <= discard + (allocated-but-unfilled slots) - (dropped rvalid this cycle);
//   rvalid arriving in the flush cycle counts as squashed.
//   No issue or dequeue takes effect in the flush cycle.
//   Issue resumes the next cycle with the redirected pc; discard drains independently.
//  Invariant: outstanding(unfilled) + discard <= DEPTH; discard width log2(DEPTH)+1.
//  rvalid with no outstanding and discard==0: protocol error; ignored, state unchanged.
//  Full (used==DEPTH): imem_req=0, pc_advance=0 (PC held) until a dequeue or flush.
//  Empty or head unfilled: inst_valid=0; inst/inst_pc hold stale slot values (don't-care).
//  rst asserted mid-operation: immediate return to reset state.
//   In-flight responses after rst release are not tracked; memory must be reset with this block.
// TESTING
//  1. Reset, gnt=1, 1-cycle rvalid, ready=1, pc 0,4,8.. -> one inst per cycle, inst_pc 0x0,0x4,0x8 in order.
//  2. ready=0, gnt=1 -> 4 grants (pc 0..0xC); then imem_req=0, pc_advance=0.
//     Raise ready -> req reasserts the cycle after the first dequeue.
//  3. Two fetches outstanding, flush pulse, pc=0x100 -> two late rvalids dropped (discard 2->0).
//     First delivered inst_pc=0x100.
//  4. rvalid and flush in same cycle with 1 outstanding -> data dropped, discard stays 0, inst_valid=0.
//  5. gnt held 0 for 5 cycles -> pc_advance=0 throughout, imem_addr stable.
//     pc=0x1003 -> imem_addr=0x1000.
//  6. Assert rst mid-burst with 3 queued -> inst_valid=0, imem_req=0 immediately; used=0 after release.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction-fetch queue: issues word reads for the current pc, buffers up to
// DEPTH {pc, instruction} pairs in issue order and hands them to decode.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc,
    output logic          pc_advance,
    input  logic          flush,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [DW-1:0] imem_rdata,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [DW-1:0] inst,
    output logic [AW-1:0] inst_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

    logic [AW-1:0]    slot_pc   [DEPTH];
    logic [DW-1:0]    slot_data [DEPTH];
    logic [DEPTH-1:0] slot_filled;

    ptr_t head, tail, fill;
    cnt_t used;
    cnt_t pend;       // allocated slots still waiting for their response
    cnt_t discard;    // responses still owed for squashed fetches
    cnt_t owed;

    logic deq, rsp_fill, rsp_drop, squash;

    // rst gates the request so it drops the moment reset is asserted
    assign imem_req   = ~rst & ~flush & (used < DEPTH_C);
    assign pc_advance = imem_req & imem_gnt;
    assign imem_addr  = pc & ~{{(AW-2){1'b0}}, 2'b11};

    assign inst_valid = slot_filled[head] & (used != '0);
    assign inst       = slot_data[head];
    assign inst_pc    = slot_pc[head];

    assign deq      = inst_valid & inst_ready;
    assign rsp_drop = imem_rvalid & (discard != '0);
    assign rsp_fill = imem_rvalid & (discard == '0) & (pend != '0);
    assign owed     = discard + pend;
    assign squash   = imem_rvalid & (owed != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            fill        <= '0;
            used        <= '0;
            pend        <= '0;
            discard     <= '0;
            slot_filled <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slot_pc[i]   <= '0;
                slot_data[i] <= '0;
            end
        end else if (flush) begin
            head        <= '0;
            tail        <= '0;
            fill        <= '0;
            used        <= '0;
            pend        <= '0;
            slot_filled <= '0;
            discard     <= owed - cnt_t'(squash);
        end else begin
            // tail, fill and head always address distinct slots when active
            if (pc_advance) begin
                slot_pc[tail]     <= pc;
                slot_filled[tail] <= 1'b0;
                tail              <= tail + ptr_t'(1);
            end
            if (rsp_drop) begin
                discard <= discard - cnt_t'(1);
            end
            if (rsp_fill) begin
                slot_data[fill]   <= imem_rdata;
                slot_filled[fill] <= 1'b1;
                fill              <= fill + ptr_t'(1);
            end
            if (deq) begin
                slot_filled[head] <= 1'b0;
                head              <= head + ptr_t'(1);
            end
            used <= used + cnt_t'(pc_advance) - cnt_t'(deq);
            pend <= pend + cnt_t'(pc_advance) - cnt_t'(rsp_fill);
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised bench for fetch_queue: a memory responder plus a queue-based
// reference model of the fetch buffer.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pc;
    logic          pc_advance;
    logic          flush;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [DW-1:0] imem_rdata;
    logic          inst_valid;
    logic          inst_ready;
    logic [DW-1:0] inst;
    logic [AW-1:0] inst_pc;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .pc_advance (pc_advance),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc)
    );

    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] data;
        bit            filled;
    } ent_t;

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } rsp_t;

    ent_t mq[$];     // expected queue contents, oldest first
    int   disc;      // expected responses still to be dropped
    rsp_t memq[$];   // memory responses in flight, in grant order

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int gnt_pct, rdy_pct, fl_pm, lat_max;
    logic s_req, s_adv;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    function automatic int m_pend();
        int p;
        p = 0;
        foreach (mq[i]) if (!mq[i].filled) p++;
        return p;
    endfunction

    task automatic check_outputs();
        bit e_req, e_val;
        e_req = (mq.size() < DEPTH) && !flush;
        e_val = (mq.size() > 0) && mq[0].filled;
        check("imem_req", 64'(imem_req), 64'(e_req));
        check("pc_advance", 64'(pc_advance), 64'(e_req && imem_gnt));
        check("inst_valid", 64'(inst_valid), 64'(e_val));
        if (e_val) begin
            check("inst_pc", 64'(inst_pc), 64'(mq[0].pc));
            check("inst", 64'(inst), 64'(mq[0].data));
        end
        if (e_req) check("imem_addr", 64'(imem_addr), 64'({pc[AW-1:2], 2'b00}));
    endtask

    // Applies one clock edge to the reference model using the inputs seen at that edge.
    task automatic model_edge();
        bit e_req, e_adv, e_deq;
        int p, owed;
        p     = m_pend();
        e_req = (mq.size() < DEPTH) && !flush;
        e_adv = e_req && imem_gnt;
        e_deq = (mq.size() > 0) && mq[0].filled && inst_ready;
        if (flush) begin
            owed = disc + p;
            if (imem_rvalid && owed > 0) owed--;
            disc = owed;
            mq.delete();
        end else begin
            if (imem_rvalid) begin
                if (disc > 0) disc--;
                else begin
                    for (int i = 0; i < mq.size(); i++) begin
                        if (!mq[i].filled) begin
                            mq[i].filled = 1'b1;
                            mq[i].data   = imem_rdata;
                            break;
                        end
                    end
                end
            end
            if (e_deq) void'(mq.pop_front());
            if (e_adv) mq.push_back('{pc: pc, data: '0, filled: 1'b0});
        end
    endtask

    task automatic drive_inputs();
        if (flush) pc = $urandom;
        else if (s_adv) pc = pc + 32'd4;
        flush       = ($urandom % 1000) < fl_pm;
        imem_gnt    = ($urandom % 100) < gnt_pct;
        inst_ready  = ($urandom % 100) < rdy_pct;
        imem_rvalid = (memq.size() > 0) && (memq[0].due <= cyc);
        imem_rdata  = imem_rvalid ? mem_word(memq[0].addr) : $urandom;
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        s_req = imem_req;
        s_adv = pc_advance;
        @(posedge clk);
        model_edge();
        cyc++;
        if (imem_rvalid) void'(memq.pop_front());
        if (s_req && imem_gnt)
            memq.push_back('{addr: imem_addr, due: cyc + int'($urandom_range(lat_max, 0))});
        #1;
        drive_inputs();
    endtask

    task automatic run(input int n, input int g, input int r, input int f, input int l);
        gnt_pct = g; rdy_pct = r; fl_pm = f; lat_max = l;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic quiet_inputs();
        flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        inst_ready = 1'b0; s_adv = 1'b0; s_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, 64'(imem_req), 64'd0);
        check({tag, "_adv"}, 64'(pc_advance), 64'd0);
        check({tag, "_valid"}, 64'(inst_valid), 64'd0);
        check({tag, "_inst"}, 64'(inst), 64'd0);
        check({tag, "_pc"}, 64'(inst_pc), 64'd0);
    endtask

    task automatic release_reset();
        mq.delete(); memq.delete(); disc = 0;
        quiet_inputs();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive_inputs();
    endtask

    initial begin
        rst = 1'b1;
        pc  = '0;
        gnt_pct = 0; rdy_pct = 0; fl_pm = 0; lat_max = 0;
        quiet_inputs();
        imem_gnt = 1'b1;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        release_reset();

        // streaming: every cycle granted, single-cycle response, decode always ready
        run(30, 100, 100, 0, 0);
        // decode stalled: queue fills to DEPTH and the request drops
        run(12, 100, 0, 0, 0);
        run(10, 100, 100, 0, 0);
        // no grants on a misaligned pc; the address must be word aligned and stable
        pc = 32'h0000_1003;
        run(8, 0, 100, 0, 0);
        run(20, 100, 100, 0, 0);
        // slow memory with frequent redirects to exercise squashing
        run(600, 100, 80, 150, 4);
        run(2000, 60, 60, 40, 3);

        // reset mid-burst with entries queued
        run(8, 100, 0, 0, 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        release_reset();
        run(1000, 70, 70, 30, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
